// File: rtl/pia_pkg.sv
// pia_pkg: shared definitions for the pia8255_hs PIA.
//   - control-word bit positions
//   - group mode enum (MODE0 / MODE1)
//   - register addresses on I_A
//   - port C bit indices used by the mode-1 handshake
//   - helpers that decode group modes and form port read data
package pia_pkg;

  typedef enum logic {
    MODE0 = 1'b0,
    MODE1 = 1'b1
  } pia_mode_e;

  // Control word fields (mode-set form, D7=1)
  localparam int CW_MODE_SET  = 7;
  localparam int CW_A_MODE_HI = 6;
  localparam int CW_A_MODE_LO = 5;
  localparam int CW_PA_IN     = 4;
  localparam int CW_PCH_IN    = 3;
  localparam int CW_B_MODE    = 2;
  localparam int CW_PB_IN     = 1;
  localparam int CW_PCL_IN    = 0;

  localparam logic [1:0] REG_PA   = 2'd0;
  localparam logic [1:0] REG_PB   = 2'd1;
  localparam logic [1:0] REG_PC   = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  // Port C handshake bit positions
  localparam logic [2:0] PC_INTR_B = 3'd0;
  localparam logic [2:0] PC_IBF_B  = 3'd1;
  localparam logic [2:0] PC_STB_B  = 3'd2;
  localparam logic [2:0] PC_INTR_A = 3'd3;
  localparam logic [2:0] PC_STB_A  = 3'd4;
  localparam logic [2:0] PC_IBF_A  = 3'd5;
  localparam logic [2:0] PC_ACK_A  = 3'd6;
  localparam logic [2:0] PC_OBF_A  = 3'd7;

  // Group A mode field 1x is treated as mode 0
  function automatic pia_mode_e group_a_mode(input logic [7:0] cw);
    return (cw[CW_A_MODE_HI:CW_A_MODE_LO] == 2'b01) ? MODE1 : MODE0;
  endfunction

  function automatic pia_mode_e group_b_mode(input logic [7:0] cw);
    return cw[CW_B_MODE] ? MODE1 : MODE0;
  endfunction

  // PA/PB read data: strobed in-latch, live pins, or the output latch
  function automatic logic [7:0] port_read(input logic       mode1,
                                           input logic       dir_in,
                                           input logic [7:0] in_latch,
                                           input logic [7:0] pins,
                                           input logic [7:0] out_latch);
    if (dir_in)
      return mode1 ? in_latch : pins;
    return out_latch;
  endfunction

endpackage

// File: rtl/pia_hs_group.sv
// pia_hs_group: one handshake group (A or B) of pia8255_hs.
// Holds the port output latch, the strobed input latch and the mode-1
// IBF / OBF_n / INTR / INTE flags together with STB_n/ACK_n edge detection.
// Ports:
//   I_CLK, I_RESET   clock, asynchronous active-high reset
//   mode1, dir_in    group in mode 1; port direction (1 = input)
//   hs_n             STB_n (input mode) or ACK_n (output mode) pin level
//   pin_d, wdata     port pins and CPU write data
//   mode_set         control-word mode set this cycle
//   port_wr          write to this group's data port
//   port_rd_rise     read of this port begins
//   port_rd_fall     read of this port has ended
//   inte_wr/inte_val bit set/reset aimed at this group's INTE
//   out_q, in_q      output latch, input latch
//   ibf, obf_n, intr, inte  handshake status
module pia_hs_group (
  input  logic       I_CLK,
  input  logic       I_RESET,
  input  logic       mode1,
  input  logic       dir_in,
  input  logic       hs_n,
  input  logic [7:0] pin_d,
  input  logic [7:0] wdata,
  input  logic       mode_set,
  input  logic       port_wr,
  input  logic       port_rd_rise,
  input  logic       port_rd_fall,
  input  logic       inte_wr,
  input  logic       inte_val,
  output logic [7:0] out_q,
  output logic [7:0] in_q,
  output logic       ibf,
  output logic       obf_n,
  output logic       intr,
  output logic       inte
);

  logic hs_p1;
  logic hs_in, hs_out, hs_low, hs_rise, stb_take;

  assign hs_in   = mode1 & dir_in;
  assign hs_out  = mode1 & ~dir_in;
  assign hs_low  = ~hs_n;
  assign hs_rise = hs_n & ~hs_p1;
  // A strobe only captures into an empty latch; a read ending in the same
  // cycle frees the latch, and the pin-side set wins.
  assign stb_take = hs_in & hs_low & (~ibf | port_rd_fall);

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      hs_p1 <= 1'b1;
      out_q <= '0;
      in_q  <= '0;
      ibf   <= 1'b0;
      obf_n <= 1'b1;
      intr  <= 1'b0;
      inte  <= 1'b0;
    end else begin
      hs_p1 <= hs_n;
      if (mode_set) begin
        out_q <= '0;
        in_q  <= '0;
        ibf   <= 1'b0;
        obf_n <= 1'b1;
        intr  <= 1'b0;
        inte  <= 1'b0;
      end else begin
        if (port_wr)  out_q <= wdata;
        if (inte_wr)  inte  <= inte_val;
        if (stb_take) in_q  <= pin_d;

        if (stb_take)
          ibf <= 1'b1;
        else if (hs_in && port_rd_fall)
          ibf <= 1'b0;

        if (hs_out && hs_low)
          obf_n <= 1'b1;
        else if (hs_out && port_wr)
          obf_n <= 1'b0;

        if (mode1 && hs_rise && inte)
          intr <= 1'b1;
        else if ((hs_in && port_rd_rise) || (hs_out && port_wr))
          intr <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pia8255_hs.sv
// pia8255_hs: clocked 8255-compatible PIA with mode 0 and mode-1 strobed
// handshake on groups A (PA + PC[7:3]) and B (PB + PC[2:0]).
// Ports:
//   I_CLK, I_RESET          clock, asynchronous active-high reset
//   I_A, I_CS, I_RD, I_WR   register select and qualified bus strobes
//   I_D / O_D               write data / combinational read data
//   I_PA, I_PB, I_PC        port pin inputs
//   O_PA, O_PB, O_PC        port outputs (PC carries mode-1 handshake bits)
//   O_PA_OE..O_PC_OE        per-bit output enables, 1 = driven
// Configuration macro PIA_SYNC_EN: when defined, the STB_n/ACK_n pins pass
// through SYNC_STAGES flops before edge detection.
module pia8255_hs #(
  parameter logic [7:0] RESET_CTRL  = 8'h9B,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       I_CLK,
  input  logic       I_RESET,
  input  logic [1:0] I_A,
  input  logic       I_CS,
  input  logic       I_RD,
  input  logic       I_WR,
  input  logic [7:0] I_D,
  output logic [7:0] O_D,
  input  logic [7:0] I_PA,
  input  logic [7:0] I_PB,
  input  logic [7:0] I_PC,
  output logic [7:0] O_PA,
  output logic [7:0] O_PB,
  output logic [7:0] O_PC,
  output logic [7:0] O_PA_OE,
  output logic [7:0] O_PB_OE,
  output logic [7:0] O_PC_OE
);
  import pia_pkg::*;

`ifdef PIA_SYNC_EN
  localparam bit SYNC_ON = 1'b1;
`else
  localparam bit SYNC_ON = 1'b0;
`endif
  localparam int SYNC_D = SYNC_ON ? SYNC_STAGES : 0;

  logic [7:0] ctrl, pc_q;
  logic       wr_p1, rd_p1;
  logic [1:0] rd_addr_p1;

  logic cs_wr, cs_rd, wr_rise, rd_rise, rd_fall;
  assign cs_wr   = I_CS & I_WR;
  assign cs_rd   = I_CS & I_RD;
  assign wr_rise = cs_wr & ~wr_p1;
  assign rd_rise = cs_rd & ~rd_p1;
  assign rd_fall = ~cs_rd & rd_p1;

  pia_mode_e mode_a, mode_b;
  logic      a_m1, b_m1, a_in, b_in, pch_in, pcl_in;
  assign mode_a = group_a_mode(ctrl);
  assign mode_b = group_b_mode(ctrl);
  assign a_m1   = (mode_a == MODE1);
  assign b_m1   = (mode_b == MODE1);
  assign a_in   = ctrl[CW_PA_IN];
  assign b_in   = ctrl[CW_PB_IN];
  assign pch_in = ctrl[CW_PCH_IN];
  assign pcl_in = ctrl[CW_PCL_IN];

  logic       ctrl_wr, mode_set, bsr, inte_a_sel, inte_b_sel;
  logic [2:0] bsr_bit;
  assign ctrl_wr  = wr_rise & (I_A == REG_CTRL);
  assign mode_set = ctrl_wr & I_D[CW_MODE_SET];
  assign bsr      = ctrl_wr & ~I_D[CW_MODE_SET];
  assign bsr_bit  = I_D[3:1];
  // In mode 1 the STB/ACK bit position addresses INTE instead of the latch
  assign inte_a_sel = bsr & a_m1 & (bsr_bit == (a_in ? PC_STB_A : PC_ACK_A));
  assign inte_b_sel = bsr & b_m1 & (bsr_bit == PC_STB_B);

  // Bus edge tracking, control word and port C latch
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      wr_p1      <= 1'b0;
      rd_p1      <= 1'b0;
      rd_addr_p1 <= REG_PA;
      ctrl       <= RESET_CTRL;
      pc_q       <= '0;
    end else begin
      wr_p1 <= cs_wr;
      rd_p1 <= cs_rd;
      if (rd_rise) rd_addr_p1 <= I_A;
      if (mode_set) begin
        ctrl <= I_D;
        pc_q <= '0;
      end else if (wr_rise && (I_A == REG_PC)) begin
        pc_q <= I_D;
      end else if (bsr && !inte_a_sel && !inte_b_sel) begin
        pc_q[bsr_bit] <= I_D[0];
      end
    end
  end

  // Handshake pin conditioning: {PC6, PC4, PC2}
  logic [2:0] hs_raw, hs_pin;
  assign hs_raw = {I_PC[PC_ACK_A], I_PC[PC_STB_A], I_PC[PC_STB_B]};

  generate
    if (SYNC_D > 0) begin : g_sync
      logic [2:0] sync_q [SYNC_D];
      always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
          for (int i = 0; i < SYNC_D; i++) sync_q[i] <= 3'b111;
        end else begin
          sync_q[0] <= hs_raw;
          for (int i = 1; i < SYNC_D; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign hs_pin = sync_q[SYNC_D-1];
    end else begin : g_nosync
      assign hs_pin = hs_raw;
    end
  endgenerate

  logic [7:0] out_a, in_a, out_b, in_b;
  logic       ibf_a, obf_n_a, intr_a, inte_a;
  logic       ibf_b, obf_n_b, intr_b, inte_b;

  pia_hs_group u_grp_a (
    .I_CLK        (I_CLK),
    .I_RESET      (I_RESET),
    .mode1        (a_m1),
    .dir_in       (a_in),
    .hs_n         (a_in ? hs_pin[1] : hs_pin[2]),
    .pin_d        (I_PA),
    .wdata        (I_D),
    .mode_set     (mode_set),
    .port_wr      (wr_rise & (I_A == REG_PA)),
    .port_rd_rise (rd_rise & (I_A == REG_PA)),
    .port_rd_fall (rd_fall & (rd_addr_p1 == REG_PA)),
    .inte_wr      (inte_a_sel),
    .inte_val     (I_D[0]),
    .out_q        (out_a),
    .in_q         (in_a),
    .ibf          (ibf_a),
    .obf_n        (obf_n_a),
    .intr         (intr_a),
    .inte         (inte_a)
  );

  pia_hs_group u_grp_b (
    .I_CLK        (I_CLK),
    .I_RESET      (I_RESET),
    .mode1        (b_m1),
    .dir_in       (b_in),
    .hs_n         (hs_pin[0]),
    .pin_d        (I_PB),
    .wdata        (I_D),
    .mode_set     (mode_set),
    .port_wr      (wr_rise & (I_A == REG_PB)),
    .port_rd_rise (rd_rise & (I_A == REG_PB)),
    .port_rd_fall (rd_fall & (rd_addr_p1 == REG_PB)),
    .inte_wr      (inte_b_sel),
    .inte_val     (I_D[0]),
    .out_q        (out_b),
    .in_q         (in_b),
    .ibf          (ibf_b),
    .obf_n        (obf_n_b),
    .intr         (intr_b),
    .inte         (inte_b)
  );

  assign O_PA    = out_a;
  assign O_PB    = out_b;
  assign O_PA_OE = {8{~a_in}};
  assign O_PB_OE = {8{~b_in}};

  // Port C: mode-1 bits override latch/pins; the STB/ACK positions read back INTE
  logic [7:0] pc_out, pc_oe, pc_rd;
  always_comb begin
    pc_out = pc_q;
    pc_oe  = {{4{~pch_in}}, {4{~pcl_in}}};
    pc_rd  = {pch_in ? I_PC[7:4] : pc_q[7:4], pcl_in ? I_PC[3:0] : pc_q[3:0]};
    if (a_m1) begin
      pc_out[PC_INTR_A] = intr_a;
      pc_oe[PC_INTR_A]  = 1'b1;
      pc_rd[PC_INTR_A]  = intr_a;
      if (a_in) begin
        pc_out[PC_IBF_A] = ibf_a;
        pc_oe[PC_IBF_A]  = 1'b1;
        pc_oe[PC_STB_A]  = 1'b0;
        pc_rd[PC_IBF_A]  = ibf_a;
        pc_rd[PC_STB_A]  = inte_a;
      end else begin
        pc_out[PC_OBF_A] = obf_n_a;
        pc_oe[PC_OBF_A]  = 1'b1;
        pc_oe[PC_ACK_A]  = 1'b0;
        pc_rd[PC_OBF_A]  = obf_n_a;
        pc_rd[PC_ACK_A]  = inte_a;
      end
    end
    if (b_m1) begin
      pc_out[PC_INTR_B] = intr_b;
      pc_out[PC_IBF_B]  = b_in ? ibf_b : obf_n_b;
      pc_oe[PC_INTR_B]  = 1'b1;
      pc_oe[PC_IBF_B]   = 1'b1;
      pc_oe[PC_STB_B]   = 1'b0;
      pc_rd[PC_INTR_B]  = intr_b;
      pc_rd[PC_IBF_B]   = b_in ? ibf_b : obf_n_b;
      pc_rd[PC_STB_B]   = inte_b;
    end
  end

  assign O_PC    = pc_out;
  assign O_PC_OE = pc_oe;

  always_comb begin
    unique case (I_A)
      REG_PA:  O_D = port_read(a_m1, a_in, in_a, I_PA, out_a);
      REG_PB:  O_D = port_read(b_m1, b_in, in_b, I_PB, out_b);
      REG_PC:  O_D = pc_rd;
      default: O_D = {1'b1, ctrl[6:0]};
    endcase
  end

endmodule
